// File: rtl/cpu_trace_buffer.sv
// Instruction trace capture for the multicycle CPU: records one entry per decoded
// instruction into a small buffer, then lets a host drain it through a req/valid port.
module cpu_trace_buffer #(
   parameter int         DEPTH        = 16,
   parameter logic [6:0] DECODE_STATE = 7'd2,
   localparam int        AW           = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [6:0]    estado,
   input  logic [31:0]   pc,
   input  logic [5:0]    opcode,
   input  logic [5:0]    funct,
   input  logic          overflow,
   input  logic          arm,
   input  logic          stop,
   input  logic          trig_en,
   input  logic [31:0]   trig_pc,
   input  logic          rd_req,
   output logic [63:0]   rd_data,
   output logic          rd_valid,
   output logic [AW:0]   count,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [AW:0]   count_q, count_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [18:0]   stamp_q, stamp_d;
   logic          sticky_q, sticky_d;
   logic [6:0]    prev_estado_q;
   logic [63:0]   rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic [63:0]   mem_q [DEPTH];

   logic          evt;
   logic          trig_hit;
   logic          wr_en;
   logic [63:0]   wr_entry;

   // Edge on entry to decode, so a decode state that lasts several cycles is one event.
   assign evt = (estado == DECODE_STATE) && (prev_estado_q != DECODE_STATE);

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      stamp_d    = stamp_q;
      sticky_d   = sticky_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      wr_en      = 1'b0;
      trig_hit   = 1'b0;
      wr_entry   = {pc, opcode, funct, sticky_q | overflow, stamp_q};

      if (arm) begin
         state_d  = ARMED;
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         stamp_d  = '0;
         sticky_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
            end
            ARMED, CAPTURE: begin
               if (stamp_q != 19'h7FFFF) begin
                  stamp_d = stamp_q + 19'd1;
               end
               trig_hit = (state_q == CAPTURE) || !trig_en || (pc == trig_pc);
               // Overflow seen in the writing cycle is already folded into the entry.
               if (evt && trig_hit) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + AW'(1);
                  count_d  = count_q + (AW+1)'(1);
                  sticky_d = 1'b0;
                  state_d  = (count_q == (AW+1)'(DEPTH - 1)) ? DONE : CAPTURE;
               end else if (overflow) begin
                  sticky_d = 1'b1;
               end
               if ((state_q == CAPTURE) && stop) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               if (rd_req && (count_q != '0)) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = mem_q[rd_ptr_q];
                  rd_ptr_d   = rd_ptr_q + AW'(1);
                  count_d    = count_q - (AW+1)'(1);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         stamp_q       <= '0;
         sticky_q      <= 1'b0;
         prev_estado_q <= '0;
         rd_data_q     <= '0;
         rd_valid_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         stamp_q       <= stamp_d;
         sticky_q      <= sticky_d;
         prev_estado_q <= estado;
         rd_data_q     <= rd_data_d;
         rd_valid_q    <= rd_valid_d;
      end
   end

   // Storage needs no reset: entries are only readable once count says they were written.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign count    = count_q;
   assign busy     = (state_q == ARMED) || (state_q == CAPTURE);
   assign done     = (state_q == DONE);

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed self-checking bench for cpu_trace_buffer: trigger modes, fill, decode
// debouncing, sticky overflow, async reset and the read port.
module tb_cpu_trace_buffer;

   localparam int         DEPTH  = 16;
   localparam int         AW     = $clog2(DEPTH);
   localparam logic [6:0] DECODE = 7'd2;
   localparam logic [6:0] OTHER  = 7'd5;
   localparam logic [5:0] OPC    = 6'h23;
   localparam logic [5:0] FN     = 6'h21;

   logic        clock;
   logic        reset;
   logic [6:0]  estado;
   logic [31:0] pc;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        overflow;
   logic        arm;
   logic        stop;
   logic        trig_en;
   logic [31:0] trig_pc;
   logic        rd_req;
   logic [63:0] rd_data;
   logic        rd_valid;
   logic [AW:0] count;
   logic        busy;
   logic        done;

   int          checks;
   int          errors;
   logic [63:0] rdat [0:19];
   logic        rval [0:19];

   cpu_trace_buffer #(.DEPTH(DEPTH), .DECODE_STATE(DECODE)) dut (
      .clock    (clock),
      .reset    (reset),
      .estado   (estado),
      .pc       (pc),
      .opcode   (opcode),
      .funct    (funct),
      .overflow (overflow),
      .arm      (arm),
      .stop     (stop),
      .trig_en  (trig_en),
      .trig_pc  (trig_pc),
      .rd_req   (rd_req),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .count    (count),
      .busy     (busy),
      .done     (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compares one observed value against its hand-derived expectation.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One instruction: a single decode cycle followed by a non-decode cycle.
   task automatic applyStimulus(input logic [31:0] p);
      estado = DECODE;
      pc     = p;
      tick();
      estado = OTHER;
      tick();
   endtask

   task automatic pulseArm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic pulseStop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic doReads(input int n);
      rd_req = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick();
         rval[i] = rd_valid;
         rdat[i] = rd_data;
      end
      rd_req = 1'b0;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b0;
      estado   = 7'd0;
      pc       = 32'd0;
      opcode   = OPC;
      funct    = FN;
      overflow = 1'b0;
      arm      = 1'b0;
      stop     = 1'b0;
      trig_en  = 1'b0;
      trig_pc  = 32'd0;
      rd_req   = 1'b0;

      tick();
      tick();
      checkOutput("rst_count", 64'(count), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_rd_valid", 64'(rd_valid), 64'd0);
      checkOutput("rst_rd_data", rd_data, 64'd0);
      reset = 1'b1;
      tick();

      // Free-running trigger, three instructions, stop, drain with one extra request.
      $display("[TB] test 1: untriggered capture and drain");
      trig_en = 1'b0;
      pulseArm();
      checkOutput("t1_busy_armed", 64'(busy), 64'd1);
      applyStimulus(32'h4);
      applyStimulus(32'h8);
      applyStimulus(32'hC);
      pulseStop();
      checkOutput("t1_count", 64'(count), 64'd3);
      checkOutput("t1_done", 64'(done), 64'd1);
      checkOutput("t1_busy", 64'(busy), 64'd0);
      doReads(4);
      checkOutput("t1_v0", 64'(rval[0]), 64'd1);
      checkOutput("t1_e0", rdat[0], {32'h4, OPC, FN, 1'b0, 19'd0});
      checkOutput("t1_v1", 64'(rval[1]), 64'd1);
      checkOutput("t1_e1", rdat[1], {32'h8, OPC, FN, 1'b0, 19'd2});
      checkOutput("t1_v2", 64'(rval[2]), 64'd1);
      checkOutput("t1_e2", rdat[2], {32'hC, OPC, FN, 1'b0, 19'd4});
      checkOutput("t1_v3_empty", 64'(rval[3]), 64'd0);
      checkOutput("t1_hold_data", rdat[3], {32'hC, OPC, FN, 1'b0, 19'd4});
      checkOutput("t1_count_end", 64'(count), 64'd0);

      // PC trigger: first two instructions precede the trigger and are dropped.
      $display("[TB] test 2: pc trigger");
      trig_en = 1'b1;
      trig_pc = 32'h20;
      pulseArm();
      checkOutput("t2_rearm_count", 64'(count), 64'd0);
      checkOutput("t2_done_cleared", 64'(done), 64'd0);
      applyStimulus(32'h10);
      applyStimulus(32'h14);
      checkOutput("t2_pre_trig_count", 64'(count), 64'd0);
      checkOutput("t2_pre_trig_busy", 64'(busy), 64'd1);
      applyStimulus(32'h20);
      applyStimulus(32'h24);
      pulseStop();
      checkOutput("t2_count", 64'(count), 64'd2);
      doReads(2);
      checkOutput("t2_e0_pc", 64'(rdat[0][63:32]), 64'h20);
      checkOutput("t2_e1_pc", 64'(rdat[1][63:32]), 64'h24);
      trig_en = 1'b0;

      // Fill: done after the 16th instruction, later ones dropped.
      $display("[TB] test 3: buffer fill");
      pulseArm();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(32'h100 + 32'(4 * i));
         if (i == 14) checkOutput("t3_not_done_15", 64'(done), 64'd0);
         if (i == 15) checkOutput("t3_done_16", 64'(done), 64'd1);
      end
      checkOutput("t3_count", 64'(count), 64'd16);
      doReads(17);
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("t3_e%0d_pc", i), 64'(rdat[i][63:32]), 64'(32'h100 + 32'(4 * i)));
      end
      checkOutput("t3_v16_empty", 64'(rval[16]), 64'd0);

      // Decode held for three cycles counts once.
      $display("[TB] test 4: long decode");
      pulseArm();
      estado = DECODE;
      pc     = 32'h200;
      tick();
      tick();
      tick();
      estado = OTHER;
      tick();
      tick();
      estado = DECODE;
      pc     = 32'h204;
      tick();
      estado = OTHER;
      tick();
      pulseStop();
      checkOutput("t4_count", 64'(count), 64'd2);

      // Overflow between instructions lands on the next entry only.
      $display("[TB] test 5: sticky overflow");
      pulseArm();
      applyStimulus(32'h40);
      overflow = 1'b1;
      tick();
      overflow = 1'b0;
      applyStimulus(32'h44);
      applyStimulus(32'h48);
      pulseStop();
      doReads(3);
      checkOutput("t5_e0_ovf", 64'(rdat[0][19]), 64'd0);
      checkOutput("t5_e1_ovf", 64'(rdat[1][19]), 64'd1);
      checkOutput("t5_e2_ovf", 64'(rdat[2][19]), 64'd0);

      // Asynchronous reset in the middle of a capture.
      $display("[TB] test 6: async reset");
      pulseArm();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(32'h300 + 32'(4 * i));
      end
      checkOutput("t6_count_pre", 64'(count), 64'd5);
      checkOutput("t6_busy_pre", 64'(busy), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("t6_count_async", 64'(count), 64'd0);
      checkOutput("t6_busy_async", 64'(busy), 64'd0);
      checkOutput("t6_done_async", 64'(done), 64'd0);
      tick();
      tick();
      reset  = 1'b1;
      rd_req = 1'b1;
      tick();
      checkOutput("t6_rd_valid_after", 64'(rd_valid), 64'd0);
      checkOutput("t6_rd_data_after", rd_data, 64'd0);
      rd_req = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
